// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: arbitration modes, word/mask types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  localparam int MAX_BUS_MASTERS = 8;
  localparam int WORD_WIDTH      = 32;

  typedef logic [WORD_WIDTH-1:0] Word_t;
  typedef logic [3:0]            ByteMask_t;

  typedef enum logic {
    ARB_ROUND_ROBIN    = 1'b0,
    ARB_FIXED_PRIORITY = 1'b1
  } ArbMode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ArbState_t;

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational winner selection among requesting masters (round-robin or fixed priority).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; o_valid is low when nobody requests.
// Ports: i_req (request vector), i_last_grant (previous owner), i_mode (policy),
//        o_winner (selected index), o_valid (at least one request present).
module rr_priority_picker
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [GW-1:0]          i_last_grant,
  input  ArbMode_t               i_mode,
  output logic [GW-1:0]          o_winner,
  output logic                   o_valid
);

  int w_idx;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    if (i_mode == ARB_FIXED_PRIORITY) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!o_valid && i_req[i]) begin
          o_winner = GW'(i);
          o_valid  = 1'b1;
        end
      end
    end else begin
      // Scan starts just past the previous owner so it goes last this round.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        w_idx = (int'(i_last_grant) + k) % NUM_MASTERS;
        if (!o_valid && i_req[w_idx]) begin
          o_winner = GW'(w_idx);
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one slave port among NUM_MASTERS masters with an IDLE/BUSY grant FSM.
// Latency: 2 cycles minimum (1 arbitration cycle + 1 slave cycle), more under s_stall.
// Backpressure: s_stall holds the owner's grant; every other requester sees m_stall=1.
// Ports: clk/rst_n (sync active-low); m_* per-master request fields and responses;
//        s_* slave-side copies of the owner's fields; grant = owner index while BUSY.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int       NUM_MASTERS = 2,
  parameter ArbMode_t ARB_MODE    = ARB_ROUND_ROBIN,
  parameter int       DATA_WIDTH  = $bits(Word_t)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_address,
  input  logic [NUM_MASTERS-1:0]                  m_read,
  input  logic [NUM_MASTERS-1:0]                  m_write,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_data_wr,
  input  ByteMask_t [NUM_MASTERS-1:0]             m_mask,
  output logic [NUM_MASTERS-1:0]                  m_stall,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_data_rd,
  output logic [DATA_WIDTH-1:0]                   s_address,
  output logic                                    s_read,
  output logic                                    s_write,
  output logic [DATA_WIDTH-1:0]                   s_data_wr,
  output ByteMask_t                               s_mask,
  input  logic                                    s_stall,
  input  logic [DATA_WIDTH-1:0]                   s_data_rd,
  output logic [$clog2(NUM_MASTERS)-1:0]          grant
);

  localparam int GW = $clog2(NUM_MASTERS);

  ArbState_t               r_state, w_state_nxt;
  logic [GW-1:0]           r_grant, w_grant_nxt;
  logic [GW-1:0]           r_last_grant, w_last_grant_nxt;
  logic [NUM_MASTERS-1:0]  w_req;
  logic [GW-1:0]           w_winner;
  logic                    w_winner_vld;
  logic                    w_busy;
  logic                    w_owner_req;

  assign w_req       = m_read | m_write;
  // Gating with rst_n drops the slave strobes in the very cycle reset is
  // asserted, before the synchronous reset edge clears the state.
  assign w_busy      = (r_state == ST_BUSY) && rst_n;
  assign w_owner_req = w_req[r_grant];
  assign grant       = r_grant;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_picker (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .i_mode       (ARB_MODE),
    .o_winner     (w_winner),
    .o_valid      (w_winner_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_MASTERS - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_winner_vld) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_winner;
        end
      end
      ST_BUSY: begin
        // Completion (slave accepted) and withdrawal both release the bus and
        // count as this master's turn for round-robin purposes.
        if (!w_owner_req || !s_stall) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_address = m_address[r_grant];
    s_data_wr = m_data_wr[r_grant];
    s_mask    = m_mask[r_grant];
    s_read    = w_busy & m_read[r_grant];
    s_write   = w_busy & m_write[r_grant];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_stall[i]   = w_req[i];
      m_data_rd[i] = '0;
      if (w_busy && (r_grant == GW'(i))) begin
        m_stall[i]   = w_req[i] & s_stall;
        m_data_rd[i] = s_data_rd;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NM = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [NM-1:0][DW-1:0]   m_address, m_data_wr;
  logic [NM-1:0]           m_read, m_write;
  ByteMask_t [NM-1:0]      m_mask;
  logic                    s_stall;
  logic [DW-1:0]           s_data_rd;

  logic [NM-1:0]           rr_m_stall, fp_m_stall;
  logic [NM-1:0][DW-1:0]   rr_m_data_rd, fp_m_data_rd;
  logic [DW-1:0]           rr_s_address, fp_s_address, rr_s_data_wr, fp_s_data_wr;
  logic                    rr_s_read, fp_s_read, rr_s_write, fp_s_write;
  ByteMask_t               rr_s_mask, fp_s_mask;
  logic [1:0]              rr_grant, fp_grant;

  bus_arbiter #(.NUM_MASTERS(NM), .ARB_MODE(ARB_ROUND_ROBIN), .DATA_WIDTH(DW)) dut_rr (
    .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(rr_m_stall), .m_data_rd(rr_m_data_rd),
    .s_address(rr_s_address), .s_read(rr_s_read), .s_write(rr_s_write),
    .s_data_wr(rr_s_data_wr), .s_mask(rr_s_mask), .s_stall(s_stall),
    .s_data_rd(s_data_rd), .grant(rr_grant));

  bus_arbiter #(.NUM_MASTERS(NM), .ARB_MODE(ARB_FIXED_PRIORITY), .DATA_WIDTH(DW)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(fp_m_stall), .m_data_rd(fp_m_data_rd),
    .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
    .s_data_wr(fp_s_data_wr), .s_mask(fp_s_mask), .s_stall(s_stall),
    .s_data_rd(s_data_rd), .grant(fp_grant));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model per DUT (0 = round-robin, 1 = fixed priority):
  // whether a master currently owns the bus, who, and whose turn was last.
  bit mb_busy  [2];
  int mb_owner [2];
  int mb_last  [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int d, input logic [NM-1:0] req);
    if (d == 1) begin
      for (int i = 0; i < NM; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= NM; k++) if (req[(mb_last[d] + k) % NM]) return (mb_last[d] + k) % NM;
    end
    return -1;
  endfunction

  task automatic model_cmp(input int d, input logic [NM-1:0] stall,
                           input logic [NM-1:0][DW-1:0] drd, input logic [DW-1:0] saddr,
                           input logic sr, input logic sw, input logic [DW-1:0] swd,
                           input ByteMask_t smask, input logic [1:0] gr);
    logic [NM-1:0]         req;
    logic [NM-1:0]         e_stall;
    logic [NM-1:0][DW-1:0] e_drd;
    bit                    busy;
    int                    o;
    string                 p;
    p    = (d == 0) ? "rr" : "fp";
    req  = m_read | m_write;
    busy = mb_busy[d] && rst_n;
    o    = mb_owner[d];
    for (int i = 0; i < NM; i++) begin
      e_stall[i] = (busy && i == o) ? (req[i] & s_stall) : req[i];
      e_drd[i]   = (busy && i == o) ? s_data_rd : '0;
    end
    check({p, ".m_stall"},   stall, e_stall);
    check({p, ".m_data_rd"}, drd,   e_drd);
    check({p, ".s_read"},    sr,    busy ? m_read[o]  : 1'b0);
    check({p, ".s_write"},   sw,    busy ? m_write[o] : 1'b0);
    if (busy) begin
      check({p, ".grant"},     gr,    o);
      check({p, ".s_address"}, saddr, m_address[o]);
      check({p, ".s_data_wr"}, swd,   m_data_wr[o]);
      check({p, ".s_mask"},    smask, m_mask[o]);
    end
  endtask

  task automatic model_step();
    logic [NM-1:0] req;
    int            w;
    req = m_read | m_write;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mb_busy[d] = 0; mb_owner[d] = 0; mb_last[d] = NM - 1;
      end else if (!mb_busy[d]) begin
        w = pick(d, req);
        if (w >= 0) begin mb_busy[d] = 1; mb_owner[d] = w; end
      end else if (!req[mb_owner[d]] || !s_stall) begin
        mb_busy[d] = 0; mb_last[d] = mb_owner[d];
      end
    end
  endtask

  // settle: move to the falling edge and compare both DUTs with the model.
  task automatic settle();
    #4;
    model_cmp(0, rr_m_stall, rr_m_data_rd, rr_s_address, rr_s_read, rr_s_write,
              rr_s_data_wr, rr_s_mask, rr_grant);
    model_cmp(1, fp_m_stall, fp_m_data_rd, fp_s_address, fp_s_read, fp_s_write,
              fp_s_data_wr, fp_s_mask, fp_grant);
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    settle();
    adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_read = '0; m_write = '0; s_stall = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int d = 0; d < 2; d++) begin mb_busy[d] = 0; mb_owner[d] = 0; mb_last[d] = NM - 1; end
    rst_n = 1'b0; m_read = '0; m_write = '0; s_stall = 1'b0; s_data_rd = 32'h0;
    for (int i = 0; i < NM; i++) begin
      m_address[i] = 32'h100 * i; m_data_wr[i] = 32'hA000 + i; m_mask[i] = 4'hF;
    end
    cycle();
    cycle();
    check("reset_grant", rr_grant, 0);
    rst_n = 1'b1;

    // Single read by master 1.
    m_read = 4'b0010; m_address[1] = 32'h10; s_data_rd = 32'h5555_AAAA;
    settle();
    check("single_stall_arb", rr_m_stall[1], 1'b1);
    check("single_no_strobe", rr_s_read, 1'b0);
    adv();
    settle();
    check("single_grant", rr_grant, 2'd1);
    check("single_s_read", rr_s_read, 1'b1);
    check("single_addr", rr_s_address, 32'h10);
    check("single_stall_done", rr_m_stall[1], 1'b0);
    check("single_rdata", rr_m_data_rd[1], 32'h5555_AAAA);
    adv();
    m_read = '0;
    settle();
    check("single_idle", rr_s_read, 1'b0);
    adv();

    // All four masters requesting continuously; reset with requests present.
    rst_n = 1'b0; m_read = 4'hF;
    settle();
    check("rst_stall_eq_req", rr_m_stall, 4'hF);
    check("rst_no_strobe", rr_s_read, 1'b0);
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (c % 2 == 1) begin
        check($sformatf("rr_order%0d", c / 2), rr_grant, exp_order[c / 2]);
        check("rr_strobe", rr_s_read, 1'b1);
      end else begin
        check("rr_arb_gap", rr_s_read, 1'b0);
      end
      adv();
    end

    // Fixed priority: masters 0 and 2 competing.
    do_reset();
    m_read = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      settle();
      check("fp_m2_stalled", fp_m_stall[2], 1'b1);
      if (c % 2 == 1) check("fp_m0_wins", fp_grant, 2'd0);
      adv();
    end

    // Slave stall: master 0 write held for 5 stalled cycles, master 1 waiting.
    do_reset();
    m_write = 4'b0001; m_data_wr[0] = 32'hDEAD_BEEF; m_mask[0] = 4'b0011;
    m_read = 4'b0010; s_stall = 1'b1;
    settle();
    check("stall_arb_nowr", rr_s_write, 1'b0);
    adv();
    for (int c = 0; c < 5; c++) begin
      settle();
      check("stall_grant", rr_grant, 2'd0);
      check("stall_s_write", rr_s_write, 1'b1);
      check("stall_wdata", rr_s_data_wr, 32'hDEAD_BEEF);
      check("stall_mask", rr_s_mask, 4'b0011);
      check("stall_m_stall", rr_m_stall, 4'b0011);
      adv();
    end
    s_stall = 1'b0;
    settle();
    check("stall_release", rr_m_stall, 4'b0010);
    adv();
    m_write = '0;
    settle();
    check("stall_idle", rr_s_write, 1'b0);
    adv();
    settle();
    check("stall_next_grant", rr_grant, 2'd1);
    check("stall_next_read", rr_s_read, 1'b1);
    adv();

    // Withdrawal of the granted master while the slave is stalling.
    do_reset();
    m_read = 4'b0101; s_stall = 1'b1;
    cycle();
    settle();
    check("wd_grant", rr_grant, 2'd0);
    adv();
    m_read = 4'b0100;
    settle();
    check("wd_no_strobe", rr_s_read, 1'b0);
    check("wd_stall", rr_m_stall, 4'b0100);
    adv();
    settle();
    check("wd_idle", rr_s_read, 1'b0);
    adv();
    settle();
    check("wd_next_grant", rr_grant, 2'd2);
    check("wd_next_read", rr_s_read, 1'b1);
    adv();

    // Reset pulse during a stalled transaction.
    do_reset();
    m_read = 4'b0010; s_stall = 1'b1;
    cycle();
    settle();
    check("rb_busy", rr_s_read, 1'b1);
    adv();
    rst_n = 1'b0; m_read = 4'b0011;
    settle();
    check("rb_strobe_drop", rr_s_read, 1'b0);
    adv();
    rst_n = 1'b1;
    settle();
    check("rb_idle", rr_s_read, 1'b0);
    adv();
    settle();
    check("rb_first_m0", rr_grant, 2'd0);
    adv();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      m_read    = NM'($urandom) & NM'($urandom);
      m_write   = NM'($urandom) & NM'($urandom);
      s_stall   = ($urandom_range(0, 2) == 0);
      s_data_rd = $urandom;
      for (int i = 0; i < NM; i++) begin
        m_address[i] = $urandom; m_data_wr[i] = $urandom; m_mask[i] = 4'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of bus masters sharing one slave (legal 2..8).
REQ-002 SHALL have parameter ARB_MODE, default ARB_ROUND_ROBIN, arbitration policy (ARB_ROUND_ROBIN or ARB_FIXED_PRIORITY, lowest index wins).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of address and data words.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port m_address  input  NUM_MASTERS x DATA_WIDTH  per-master address.
REQ-007 SHALL have port m_read, m_write  input  NUM_MASTERS  per-master request strobes.
REQ-008 SHALL have port m_data_wr  input  NUM_MASTERS x DATA_WIDTH  per-master write data.
REQ-009 SHALL have port m_mask  input  NUM_MASTERS x 4  per-master byte mask.
REQ-010 SHALL have port m_stall  output  NUM_MASTERS  per-master stall.
REQ-011 SHALL have port m_data_rd  output  NUM_MASTERS x DATA_WIDTH  per-master read data.
REQ-012 SHALL have ports s_address, s_read, s_write, s_data_wr, s_mask  output  slave-side copies of the master fields.
REQ-013 SHALL have ports s_stall (1), s_data_rd (DATA_WIDTH)  input  slave responses.
REQ-014 SHALL have port grant  output  $clog2(NUM_MASTERS)  index of current owner, valid in BUSY.

Function
REQ-015 SHALL define request of master i as m_read[i] | m_write[i].
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 In IDLE, any request SHALL register the winner into grant and move to BUSY next cycle; no request keeps IDLE.
REQ-018 Round-robin SHALL search from (last_grant+1) mod NUM_MASTERS upward with wrap; fixed-priority SHALL pick the lowest requesting index.
REQ-019 In BUSY, the granted master's fields SHALL drive the slave outputs combinationally; in IDLE, s_read and s_write SHALL be 0.
REQ-020 In BUSY, m_stall[grant] SHALL equal s_stall, and m_data_rd[grant] SHALL equal s_data_rd.
REQ-021 Every requesting non-granted master, and every requesting master in IDLE, SHALL see m_stall=1.
REQ-022 A non-requesting master SHALL see m_stall=0; m_data_rd of non-granted masters SHALL be 0.
REQ-023 A transaction SHALL complete in a BUSY cycle with request and s_stall=0; the FSM then latches last_grant=grant and returns to IDLE.
REQ-024 Minimum latency SHALL be 2 cycles from request to completion: 1 arbitration cycle plus 1 slave cycle.
REQ-025 Grant SHALL be held for any number of s_stall cycles; no preemption.
REQ-026 If the granted master drops its request in BUSY, the FSM SHALL return to IDLE without a slave access, and last_grant SHALL be updated.
REQ-027 Simultaneous m_read and m_write SHALL be forwarded unchanged; legality is the slave's concern.

Reset
REQ-028 While rst_n=0 at a clock edge, the state SHALL go to IDLE, grant to 0, and last_grant to NUM_MASTERS-1, so master 0 is first in round-robin.
REQ-029 During reset, s_read=s_write=0, and m_stall SHALL equal the request per REQ-021.
REQ-030 A reset asserted mid-transaction SHALL abort it in the same edge; the slave sees the strobes drop.

Structure
REQ-031 The ArbMode_t enum (ARB_ROUND_ROBIN, ARB_FIXED_PRIORITY) and the MAX_BUS_MASTERS=8 constant SHALL be placed in the shared definitions package; Word_t and ByteMask_t SHALL be reused from it.
REQ-032 The winner selection SHALL be one combinational sub-module, rr_priority_picker (inputs: request vector, last_grant, mode; output: winner index, valid).

Verification
REQ-033 Single request: master 1 reads 0x00000010 with s_stall=0 -> grant=1 on cycle 1, s_read=1 for one cycle, m_stall[1]=1,0, then IDLE.
REQ-034 Round-robin contention: NUM_MASTERS=4, all requesting continuously -> grant order 0,1,2,3,0, each transaction taking 2 cycles.
REQ-035 Fixed priority: masters 0 and 2 requesting continuously -> master 0 always wins and master 2 stays stalled.
REQ-036 Slave stall: s_stall=1 for 5 cycles during master 0 write 0xDEADBEEF mask 4'b0011 -> grant held, master 1 stalled, write completes on cycle 7.
REQ-037 Request withdrawal: granted master deasserts in BUSY -> no slave strobe, IDLE next cycle, next requester granted.
REQ-038 Reset mid-BUSY: rst_n=0 for 1 cycle -> s_read/s_write=0 on the next edge, and master 0 is granted first after release.
